// File: rtl/servo_pulse_decoder_pkg.sv
// Servo pulse encoding constants shared with the PWM driver, plus the decoder FSM encoding.
// Code n is sent as a high time of MIN + n*STEP clocks; the decoder accepts +/- half a step around each code.
package servo_pulse_decoder_pkg;

    localparam int SERVO_MIN_COUNT     = 25000;
    localparam int SERVO_STEP_COUNT    = 320;
    localparam int SERVO_HALF_STEP     = SERVO_STEP_COUNT / 2;
    localparam int SERVO_ACCEPT_MIN    = SERVO_MIN_COUNT - SERVO_HALF_STEP;              // 24840
    localparam int SERVO_ACCEPT_MAX    = SERVO_ACCEPT_MIN + 256 * SERVO_STEP_COUNT - 1;  // 106759
    localparam int SERVO_TIMEOUT_COUNT = 3200000;
    localparam int SERVO_CNT_W         = 22;

    typedef enum logic [2:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE,
        CHECK,
        DIVIDE,
        DONE
    } state_t;

endpackage

// File: rtl/servo_pulse_decoder_divider.sv
// Restoring divider (17-bit dividend / 9-bit divisor -> 8-bit quotient), fixed 8 cycles after start.
// done and quotient are valid together in the 8th busy cycle; a new start aborts and restarts.
module serial_divider_u17_u9 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [16:0] dividend,
    input  logic [8:0]  divisor,
    output logic        done,
    output logic [7:0]  quotient
);

    logic [16:0] rem;
    logic [16:0] dsh;
    logic [6:0]  q;
    logic [2:0]  cnt;
    logic        busy;
    logic        fits;

    // dividend < divisor*256 is guaranteed by the caller, so 8 quotient bits suffice
    assign fits     = (rem >= dsh);
    assign done     = busy && (cnt == 3'd7);
    assign quotient = {q, fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem  <= '0;
            dsh  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= dividend;
            dsh  <= {1'b0, divisor, 7'b0};
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (fits) begin
                rem <= rem - dsh;
            end
            dsh <= dsh >> 1;
            q   <= {q[5:0], fits};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time and converts it back to the 8-bit position code.
// data_valid fires 10 clocks after the synchronized falling edge; pulse_error 2 clocks after.
module servo_pulse_decoder
    import servo_pulse_decoder_pkg::*;
#(
    parameter int MIN_COUNT     = SERVO_MIN_COUNT,
    parameter int STEP_COUNT    = SERVO_STEP_COUNT,
    parameter int TIMEOUT_COUNT = SERVO_TIMEOUT_COUNT,
    parameter int CNT_W         = SERVO_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pulse_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       pulse_error,
    output logic       signal_lost
);

    localparam int LOWER = MIN_COUNT - STEP_COUNT / 2;
    localparam int UPPER = LOWER + 256 * STEP_COUNT - 1;

    localparam logic [CNT_W-1:0] LOWER_W   = CNT_W'(LOWER);
    localparam logic [CNT_W-1:0] UPPER_W   = CNT_W'(UPPER);
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_COUNT);
    localparam logic [8:0]       DIVISOR   = 9'(STEP_COUNT);

    logic             sync_meta;
    logic             pulse_sync;
    logic             pulse_prev;
    logic             rise;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] tcount;
    logic             timeout_hit;
    logic             in_range;
    logic [16:0]      offset;

    logic             div_start;
    logic             div_done;
    logic [7:0]       div_quotient;
    logic             reject;
    logic             finish;
    logic             rise_seen;

    // Left unreset on purpose: a pulse already high at reset release must still read as high
    always_ff @(posedge clk) begin
        sync_meta  <= pulse_in;
        pulse_sync <= sync_meta;
        pulse_prev <= pulse_sync;
    end

    assign rise        = pulse_sync & ~pulse_prev;
    assign timeout_hit = (tcount == TIMEOUT_W);
    assign in_range    = (width >= LOWER_W) && (width <= UPPER_W);
    assign offset      = 17'(width - LOWER_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        reject    = 1'b0;
        finish    = 1'b0;
        rise_seen = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!pulse_sync) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    rise_seen = 1'b1;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout_hit) begin
                    state_d = WAIT_LOW;
                end else if (!pulse_sync) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (in_range) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end else begin
                    reject  = 1'b1;
                    state_d = WAIT_LOW;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = WAIT_RISE;
            end
            default: begin
                state_d = WAIT_LOW;
            end
        endcase
        if (!enable) begin
            state_d   = WAIT_LOW;
            div_start = 1'b0;
            reject    = 1'b0;
            finish    = 1'b0;
            rise_seen = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            width       <= '0;
            tcount      <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            pulse_error <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            data_valid  <= finish;
            pulse_error <= reject;
            if (finish) begin
                data <= div_quotient;
            end
            if (!enable) begin
                width  <= '0;
                tcount <= '0;
            end else begin
                if (rise_seen) begin
                    tcount <= '0;
                end else if (!timeout_hit) begin
                    tcount <= tcount + CNT_W'(1);
                end
                if (rise_seen) begin
                    width <= CNT_W'(1);
                end else if (state_q == MEASURE && pulse_sync && width != '1) begin
                    width <= width + CNT_W'(1);
                end
            end
            // A bare rising edge is not proof of a good signal; only a decoded pulse clears the flag
            if (finish) begin
                signal_lost <= 1'b0;
            end else if (timeout_hit) begin
                signal_lost <= 1'b1;
            end
        end
    end

    serial_divider_u17_u9 u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (offset),
        .divisor  (DIVISOR),
        .done     (div_done),
        .quotient (div_quotient)
    );

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with scaled-down encoding constants (MIN=50, STEP=4, TIMEOUT=5000).
module tb_servo_pulse_decoder;

    localparam int MIN_C  = 50;
    localparam int STEP_C = 4;
    localparam int TO_C   = 5000;
    localparam int CW     = 22;
    // Clocks from the falling input edge to each strobe: 2 synchronizer flops plus T+2 / T+10
    localparam int ERR_AT = 4;
    localparam int DV_AT  = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pulse_in;
    logic [7:0] data;
    logic       data_valid;
    logic       pulse_error;
    logic       signal_lost;

    int n_checks = 0;
    int n_fail   = 0;

    int         dv_cnt, err_cnt, dv_at, err_at, dv_sl, sl_before, last_code;
    logic [7:0] dv_dat;

    typedef struct {
        int width;
        bit ok;
        int code;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    servo_pulse_decoder #(
        .MIN_COUNT     (MIN_C),
        .STEP_COUNT    (STEP_C),
        .TIMEOUT_COUNT (TO_C),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .data        (data),
        .data_valid  (data_valid),
        .pulse_error (pulse_error),
        .signal_lost (signal_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_watch();
        dv_cnt  = 0;
        err_cnt = 0;
        dv_at   = -1;
        err_at  = -1;
        dv_sl   = -1;
        dv_dat  = '0;
    endtask

    // Advance n clocks, recording every strobe; *_at is relative to the start of this call
    task automatic watch(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (data_valid) begin
                dv_cnt++;
                dv_at  = k;
                dv_dat = data;
                dv_sl  = signal_lost;
            end
            if (pulse_error) begin
                err_cnt++;
                err_at = k;
            end
        end
    endtask

    task automatic send_pulse(input int width);
        pulse_in = 1'b0;
        watch(3);
        clear_watch();
        pulse_in = 1'b1;
        watch(width);
        sl_before = signal_lost;
        pulse_in  = 1'b0;
        watch(30);
    endtask

    task automatic expect_accept(input string name, input int code);
        check({name, " dv_count"}, dv_cnt, 1);
        check({name, " dv_latency"}, dv_at, DV_AT);
        check({name, " data"}, dv_dat, code);
        check({name, " err_count"}, err_cnt, 0);
        last_code = code;
    endtask

    task automatic expect_reject(input string name);
        check({name, " err_count"}, err_cnt, 1);
        check({name, " err_latency"}, err_at, ERR_AT);
        check({name, " dv_count"}, dv_cnt, 0);
        check({name, " data_held"}, data, last_code);
    endtask

    initial begin
        vecs[0]  = '{50,   1'b1, 0};
        vecs[1]  = '{1070, 1'b1, 255};
        vecs[2]  = '{563,  1'b1, 128};
        vecs[3]  = '{564,  1'b1, 129};
        vecs[4]  = '{48,   1'b1, 0};
        vecs[5]  = '{1071, 1'b1, 255};
        vecs[6]  = '{47,   1'b0, 0};
        vecs[7]  = '{1072, 1'b0, 0};
        vecs[8]  = '{358,  1'b1, 77};
        vecs[9]  = '{850,  1'b1, 200};
        vecs[10] = '{1070, 1'b1, 255};
        vecs[11] = '{50,   1'b1, 0};

        last_code = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        pulse_in  = 1'b0;
        clear_watch();
        watch(5);
        reset = 1'b0;
        check("reset data", data, 0);
        check("reset data_valid", data_valid, 0);
        check("reset pulse_error", pulse_error, 0);
        check("reset signal_lost", signal_lost, 1);

        // First frame: nominal mid-scale pulse
        send_pulse(562);
        expect_accept("first", 128);
        check("first sl_before_dv", sl_before, 1);
        check("first sl_at_dv", dv_sl, 0);

        for (int i = 0; i < 12; i++) begin
            send_pulse(vecs[i].width);
            if (vecs[i].ok) begin
                expect_accept($sformatf("vec%0d w=%0d", i, vecs[i].width), vecs[i].code);
            end else begin
                expect_reject($sformatf("vec%0d w=%0d", i, vecs[i].width));
            end
        end

        // Loss of signal: input idles low past the timeout
        clear_watch();
        watch(4000);
        check("idle sl_before_timeout", signal_lost, 0);
        watch(1000);
        check("idle sl_after_timeout", signal_lost, 1);
        check("idle strobes", dv_cnt + err_cnt, 0);
        send_pulse(850);
        expect_accept("recover", 200);
        check("recover sl_on_edge", sl_before, 1);
        check("recover sl_at_dv", dv_sl, 0);

        // Pulse stuck high past the timeout
        clear_watch();
        pulse_in = 1'b1;
        watch(TO_C + 200);
        check("stuck sl", signal_lost, 1);
        pulse_in = 1'b0;
        watch(30);
        check("stuck strobes", dv_cnt + err_cnt, 0);
        send_pulse(1070);
        expect_accept("after_stuck", 255);

        // enable dropped mid-pulse
        clear_watch();
        pulse_in = 1'b1;
        watch(200);
        enable = 1'b0;
        watch(1000);
        enable = 1'b1;
        watch(100);
        pulse_in = 1'b0;
        watch(30);
        check("enable_drop strobes", dv_cnt + err_cnt, 0);
        check("enable_drop data", data, 255);
        send_pulse(358);
        expect_accept("after_enable", 77);

        // Reset released while the pulse is still high
        clear_watch();
        pulse_in = 1'b1;
        watch(200);
        reset = 1'b1;
        watch(3);
        reset = 1'b0;
        watch(359);
        pulse_in = 1'b0;
        watch(30);
        check("midreset strobes", dv_cnt + err_cnt, 0);
        check("midreset data", data, 0);
        check("midreset sl", signal_lost, 1);
        send_pulse(562);
        expect_accept("after_midreset", 128);
        check("after_midreset sl_at_dv", dv_sl, 0);

        // Reset while the divider is running
        pulse_in = 1'b0;
        watch(3);
        pulse_in = 1'b1;
        watch(562);
        pulse_in = 1'b0;
        clear_watch();
        watch(6);
        reset = 1'b1;
        watch(2);
        reset = 1'b0;
        watch(30);
        check("divreset dv_count", dv_cnt, 0);
        check("divreset data", data, 0);
        check("divreset sl", signal_lost, 1);
        send_pulse(358);
        expect_accept("after_divreset", 77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
